// File: rtl/rr_arbiter_if.sv
// rr_arbiter_if -- request/grant bundle between a set of requesters and
// the round-robin arbiter.
//
// Parameters:
//   NUM_REQ   - number of requesters
//   IDX_WIDTH - width of the encoded grant index, clog2(NUM_REQ)
//
// Signals:
//   req       - level-sensitive request vector, one bit per requester
//   done      - single-cycle release pulse from the current owner
//   gnt       - one-hot grant, all-zero when idle
//   gnt_idx   - binary index of the granted requester
//   gnt_valid - high while a grant is held
//   timeout   - single-cycle pulse on a forced release
//
// Modports:
//   master - requester side (drives req/done, observes the grant)
//   slave  - arbiter side (observes req/done, drives the grant)
interface rr_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = 2
);
  logic [NUM_REQ-1:0]   req;
  logic                 done;
  logic [NUM_REQ-1:0]   gnt;
  logic [IDX_WIDTH-1:0] gnt_idx;
  logic                 gnt_valid;
  logic                 timeout;

  modport master (
    output req, done,
    input  gnt, gnt_idx, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_idx, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter -- round-robin arbiter with a two-state (IDLE/GRANT) FSM and
// fully registered outputs.
//
// In IDLE the first requesting bit at or after the priority pointer wins
// (searching upward with wrap-around). The grant is held until the owner
// pulses done, withdraws its request, or (optionally) a hold timeout
// fires. Every release moves the pointer to just past the old owner and
// forces one idle cycle before the next grant.
//
// Optional feature macro: RR_ARB_TIMEOUT_EN
//   defined   - a hold counter forces a release after TIMEOUT_CYCLES
//               grant cycles and pulses timeout
//   undefined - no counter, timeout tied low, grants held indefinitely
//
// Parameters:
//   NUM_REQ        - number of requesters (2..16)
//   IDX_WIDTH      - grant index width, must equal clog2(NUM_REQ)
//   TIMEOUT_CYCLES - maximum grant hold (timeout build only)
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst_n - synchronous active-low reset
//   bus   - rr_arbiter_if slave modport (req, done in; gnt, gnt_idx,
//           gnt_valid, timeout out)
module rr_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDX_WIDTH      = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  rr_arbiter_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ - 1);
  localparam logic [IDX_WIDTH:0]   NUM_REQ_W = (IDX_WIDTH + 1)'(NUM_REQ);

  // Elaboration-time sanity checks on the parameter set.
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("rr_arbiter: NUM_REQ must be in 2..16");
  end
  if (IDX_WIDTH != $clog2(NUM_REQ)) begin : g_bad_idx_width
    $error("rr_arbiter: IDX_WIDTH must equal clog2(NUM_REQ)");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("rr_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  logic [0:0]           state;
  logic [IDX_WIDTH-1:0] ptr;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [IDX_WIDTH-1:0] gnt_idx_q;
  logic                 gnt_valid_q;

  logic                 found;
  logic [IDX_WIDTH-1:0] sel_idx;
  logic [IDX_WIDTH:0]   cand_sum;
  logic [IDX_WIDTH-1:0] cand;
  logic [IDX_WIDTH-1:0] next_ptr;
  logic                 owner_release;
  logic                 release_now;

  // Rotating priority search. Walking offsets from highest to lowest and
  // overwriting means the last hit kept is the one closest to ptr. The
  // one-extra-bit sum plus a single conditional subtract implements the
  // modulo so non-power-of-2 NUM_REQ wraps correctly.
  always_comb begin
    found    = 1'b0;
    sel_idx  = ptr;
    cand_sum = '0;
    cand     = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand_sum = {1'b0, ptr} + (IDX_WIDTH + 1)'(i);
      if (cand_sum >= NUM_REQ_W) begin
        cand_sum = cand_sum - NUM_REQ_W;
      end
      cand = cand_sum[IDX_WIDTH-1:0];
      if (bus.req[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

  // Pointer moves to just past the released owner, wrapping at NUM_REQ-1.
  assign next_ptr      = (gnt_idx_q == LAST_IDX) ? '0 : gnt_idx_q + 1'b1;
  assign owner_release = bus.done | ~bus.req[gnt_idx_q];

`ifdef RR_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             hold_expired;
  logic             timeout_q;

  assign hold_expired = (hold_cnt == HOLD_LIMIT);
  assign release_now  = owner_release | hold_expired;

  // Hold counter is parked at zero while idle so it is already clear on
  // the IDLE->GRANT edge. The timeout pulse only fires when the counter
  // alone causes the release; a simultaneous done/withdraw wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (state == ST_IDLE) begin
        hold_cnt <= '0;
      end else if (!release_now) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
      if (state == ST_GRANT && hold_expired && !owner_release) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign release_now = owner_release;
  assign bus.timeout = 1'b0;
`endif

  // Main FSM. Grant outputs are registered here directly, so they change
  // only on the edge that enters or leaves GRANT; gnt_idx deliberately
  // keeps its old value through idle periods.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (found) begin
        state       <= ST_GRANT;
        gnt_q       <= NUM_REQ'(1) << sel_idx;
        gnt_idx_q   <= sel_idx;
        gnt_valid_q <= 1'b1;
      end
    end else begin
      if (release_now) begin
        state       <= ST_IDLE;
        ptr         <= next_ptr;
        gnt_q       <= '0;
        gnt_valid_q <= 1'b0;
      end
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;

endmodule
